// File: rtl/base4_multiplier.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Retires one Booth digit per cycle, with a one-entry result cache and a zero-operand shortcut.
module base4_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [1:0]       op,
  input  logic             input_valid,
  output logic [WIDTH-1:0] result,
  output logic             output_valid,
  output logic             busy
);

  localparam int DIGITS = (WIDTH + 2) / 2;
  localparam int AW     = 2 * WIDTH + 2;
  localparam int BW     = WIDTH + 2;
  localparam int CW     = $clog2(DIGITS);

  typedef enum logic [2:0] {IDLE, PREPROCESS, MULTIPLY, DONE, CACHED} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [1:0]        op_q;
  logic [AW-1:0]     mcand_q;
  logic [BW-1:0]     mplier_q;
  logic              bprev_q;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  cache_a_q, cache_b_q, cache_res_q;
  logic [1:0]        cache_op_q;
  logic              cache_vld_q;
  logic [WIDTH-1:0]  result_q;
  logic              ovld_q;
  logic [WIDTH-1:0]  prod_slice;
  logic              cache_hit, zero_op, a_sgn, b_sgn;

  // Booth digit {-2,-1,0,+1,+2} selected by bits {b[2i+1], b[2i], b[2i-1]}.
  function automatic logic [AW-1:0] booth_term(input logic [2:0] bits, input logic [AW-1:0] a);
    logic [AW-1:0] t;
    case (bits)
      3'b001, 3'b010: t = a;
      3'b011:         t = a << 1;
      3'b100:         t = -(a << 1);
      3'b101, 3'b110: t = -a;
      default:        t = '0;
    endcase
    return t;
  endfunction

  always_comb begin
    acc_d      = acc_q + booth_term({mplier_q[1:0], bprev_q}, mcand_q);
    prod_slice = (op_q == 2'b00) ? acc_d[WIDTH-1:0] : acc_d[2*WIDTH-1:WIDTH];
    cache_hit  = cache_vld_q && (a_q == cache_a_q) && (b_q == cache_b_q) && (op_q == cache_op_q);
    zero_op    = (a_q == '0) || (b_q == '0);
    a_sgn      = ((op_q == 2'b01) || (op_q == 2'b10)) && a_q[WIDTH-1];
    b_sgn      = (op_q == 2'b01) && b_q[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      bprev_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_op_q  <= '0;
      cache_res_q <= '0;
      cache_vld_q <= 1'b0;
      result_q    <= '0;
      ovld_q      <= 1'b0;
    end else begin
      ovld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (input_valid) begin
            a_q     <= multiplicand;
            b_q     <= multiplier;
            op_q    <= op;
            state_q <= PREPROCESS;
          end
        end
        PREPROCESS: begin
          if (cache_hit) begin
            result_q <= cache_res_q;
            ovld_q   <= 1'b1;
            state_q  <= CACHED;
          end else if (zero_op) begin
            result_q <= '0;
            ovld_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            mcand_q  <= {{(AW-WIDTH){a_sgn}}, a_q};
            mplier_q <= {{(BW-WIDTH){b_sgn}}, b_q};
            bprev_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= CW'(DIGITS - 1);
            state_q  <= MULTIPLY;
          end
        end
        MULTIPLY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 2;
          mplier_q <= {2'b00, mplier_q[BW-1:2]};
          bprev_q  <= mplier_q[1];
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= prod_slice;
            ovld_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // result_q already holds this operation's answer; capture it for reuse.
          cache_a_q   <= a_q;
          cache_b_q   <= b_q;
          cache_op_q  <= op_q;
          cache_res_q <= result_q;
          cache_vld_q <= 1'b1;
          state_q     <= IDLE;
        end
        CACHED:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result       = result_q;
  assign output_valid = ovld_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_base4_multiplier.sv
// Self-checking bench for base4_multiplier: directed corners plus randomized back-to-back traffic
// compared against a plain 64-bit arithmetic model with a one-entry cache latency model.
module tb_base4_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier   = '0;
  logic [1:0]  op = 2'b00;
  logic        input_valid = 1'b0;
  logic [31:0] result;
  logic        output_valid;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  logic        mc_vld = 1'b0;
  logic [31:0] mc_a, mc_b;
  logic [1:0]  mc_op;

  base4_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .multiplicand(multiplicand), .multiplier(multiplier), .op(op),
    .input_valid(input_valid), .result(result), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Expected latency under the one-entry cache rule; updates the cache model.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    if (mc_vld && mc_a == a && mc_b == b && mc_op == o) return 2;
    mc_vld = 1'b1; mc_a = a; mc_b = b; mc_op = o;
    return (a == 0 || b == 0) ? 2 : 19;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       output int lat, output logic [31:0] res, output bit busy_ok);
    @(negedge clk);
    multiplicand = a; multiplier = b; op = o; input_valid = 1'b1;
    lat = 0; res = '0; busy_ok = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      input_valid = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (output_valid) begin
        lat = n; res = result;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mc_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    nvec++;
    if (result !== 32'h0 || output_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset: result=%h ovld=%b busy=%b, want 0/0/0", result, output_valid, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] res; bit bok;
    issue(32'd7, 32'd6, 2'b00, lat, res, bok);
    nvec++; if (lat !== 19) begin nerr++; $display("FAIL basic_lat: got %0d want 19", lat); end
    nvec++; if (res !== 32'd42) begin nerr++; $display("FAIL basic_res: got %h want 0000002a", res); end
    nvec++; if (!bok) begin nerr++; $display("FAIL basic_busy: busy dropped before completion"); end
  endtask

  task automatic test_mulhu_cache();
    int lat; logic [31:0] res; bit bok;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, lat, res, bok);
    nvec++; if (lat !== 19 || res !== 32'hFFFFFFFE) begin nerr++; $display("FAIL mulhu: lat=%0d res=%h want 19/fffffffe", lat, res); end
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, lat, res, bok);
    nvec++; if (lat !== 2 || res !== 32'hFFFFFFFE) begin nerr++; $display("FAIL mulhu_hit: lat=%0d res=%h want 2/fffffffe", lat, res); end
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, lat, res, bok);
    nvec++; if (lat !== 19 || res !== 32'h00000001) begin nerr++; $display("FAIL mul_opmiss: lat=%0d res=%h want 19/00000001", lat, res); end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; bit bok;
    issue(32'h80000000, 32'h80000000, 2'b01, lat, res, bok);
    nvec++; if (lat !== 19 || res !== 32'h40000000) begin nerr++; $display("FAIL mulh_min: lat=%0d res=%h want 19/40000000", lat, res); end
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, lat, res, bok);
    nvec++; if (lat !== 19 || res !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mulhsu: lat=%0d res=%h want 19/ffffffff", lat, res); end
    issue(32'hFFFFFFFF, 32'h00000002, 2'b01, lat, res, bok);
    nvec++; if (lat !== 19 || res !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mulh_neg: lat=%0d res=%h want 19/ffffffff", lat, res); end
  endtask

  task automatic test_zero();
    int lat; logic [31:0] res; bit bok;
    issue(32'h0, 32'h1234, 2'b00, lat, res, bok);
    nvec++; if (lat !== 2 || res !== 32'h0) begin nerr++; $display("FAIL zero_op: lat=%0d res=%h want 2/00000000", lat, res); end
    issue(32'h0, 32'h1234, 2'b00, lat, res, bok);
    nvec++; if (lat !== 2 || res !== 32'h0) begin nerr++; $display("FAIL zero_hit: lat=%0d res=%h want 2/00000000", lat, res); end
  endtask

  task automatic test_ignored_request();
    int pulses = 0; int first = 0; logic [31:0] res = '0;
    @(negedge clk);
    multiplicand = 32'd12345; multiplier = 32'd6789; op = 2'b00; input_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      input_valid = (n == 5);
      if (n == 5) begin multiplicand = 32'd3; multiplier = 32'd5; end
      if (output_valid) begin
        pulses++;
        if (first == 0) begin first = n; res = result; end
      end
    end
    input_valid = 1'b0;
    nvec++; if (pulses !== 1) begin nerr++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    nvec++; if (first !== 19 || res !== 32'd83810205) begin nerr++; $display("FAIL ignore_res: lat=%0d res=%0d want 19/83810205", first, res); end
  endtask

  task automatic test_midop_reset();
    int pulses = 0; int lat; logic [31:0] res; bit bok;
    @(negedge clk);
    multiplicand = 32'hDEADBEEF; multiplier = 32'h12345678; op = 2'b11; input_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      input_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    nvec++; if (output_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL midreset: ovld=%b busy=%b want 0/0", output_valid, busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (output_valid) pulses++;
    end
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL midreset_pulse: got %0d pulses want 0", pulses); end
    issue(32'hDEADBEEF, 32'h12345678, 2'b11, lat, res, bok);
    nvec++; if (lat !== 19 || res !== model_prod(32'hDEADBEEF, 32'h12345678, 2'b11)) begin
      nerr++; $display("FAIL reset_miss: lat=%0d res=%h want 19/%h", lat, res, model_prod(32'hDEADBEEF, 32'h12345678, 2'b11));
    end
  endtask

  task automatic test_random();
    logic [31:0] a = 32'h1, b = 32'h1, ea; logic [1:0] o = 2'b00;
    int lat, elat; logic [31:0] res; bit bok;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       ; // repeat previous request
        1:       begin a = 32'h0; b = $urandom; o = 2'($urandom); end
        2:       begin a = $urandom; b = 32'h0; o = 2'($urandom); end
        3:       begin a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF; b = $urandom; o = 2'($urandom); end
        4:       begin o = 2'($urandom); end
        default: begin a = $urandom; b = $urandom; o = 2'($urandom); end
      endcase
      elat = model_lat(a, b, o);
      ea   = model_prod(a, b, o);
      issue(a, b, o, lat, res, bok);
      nvec++;
      if (lat !== elat || res !== ea) begin
        nerr++;
        $display("FAIL random[%0d] a=%h b=%h op=%0d: lat=%0d res=%h want %0d/%h", i, a, b, o, lat, res, elat, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mulhu_cache();
    test_signed();
    test_zero();
    test_ignored_request();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
